// File: rtl/page_walk_responder_pkg.sv
// Shared types, widths and translation helpers for the page walk responder.
// Translation is identity with the physical page MSB forced high.
package page_walk_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WALK,
      ST_RESP
   } state_t;

   typedef enum logic {
      SEL_8B,
      SEL_32B
   } sel_t;

   localparam int VPN8_W  = 6;
   localparam int VPN32_W = 4;
   localparam int RET8_W  = 12;
   localparam int RET32_W = 8;
   localparam logic PA_MSB_SET = 1'b1;

   function automatic logic [RET8_W-1:0] xlate8(
      input logic [VPN8_W-1:0] vpn
   );
      return {vpn, PA_MSB_SET, vpn[4:0]};
   endfunction

   function automatic logic [RET32_W-1:0] xlate32(
      input logic [VPN32_W-1:0] vpn
   );
      return {vpn, PA_MSB_SET, vpn[2:0]};
   endfunction

endpackage

// File: rtl/page_walk_responder_if.sv
// TLB page-table lookup bus: one request/response group per page size.
// master = TLB side, slave = responder side.
interface page_walk_responder_if;
   import page_walk_responder_pkg::*;

   logic               PAGE_8B_RQST;
   logic [VPN8_W-1:0]  PAGE_8B_LOOKUP;
   logic [RET8_W-1:0]  PAGE_8B_RECV;
   logic               PAGE_8B_COMPLETE;
   logic               PAGE_32B_RQST;
   logic [VPN32_W-1:0] PAGE_32B_LOOKUP;
   logic [RET32_W-1:0] PAGE_32B_RECV;
   logic               PAGE_32B_COMPLETE;

   modport master (
      output PAGE_8B_RQST, PAGE_8B_LOOKUP,
      output PAGE_32B_RQST, PAGE_32B_LOOKUP,
      input  PAGE_8B_RECV, PAGE_8B_COMPLETE,
      input  PAGE_32B_RECV, PAGE_32B_COMPLETE
   );

   modport slave (
      input  PAGE_8B_RQST, PAGE_8B_LOOKUP,
      input  PAGE_32B_RQST, PAGE_32B_LOOKUP,
      output PAGE_8B_RECV, PAGE_8B_COMPLETE,
      output PAGE_32B_RECV, PAGE_32B_COMPLETE
   );

endinterface

// File: rtl/page_walk_responder_arbiter.sv
// Eligibility and fixed-priority select; owns the per-port served flags
// that stop a still-held request from being walked twice.
module pwr_arbiter
   import page_walk_responder_pkg::*;
#(
   parameter bit PRIO_32B = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rqst8,
   input  logic rqst32,
   input  logic done8,
   input  logic done32,
   output logic any_elig,
   output sel_t win
);

   logic served8_q, served8_d;
   logic served32_q, served32_d;
   logic elig8, elig32;

   assign elig8    = rqst8 & ~served8_q;
   assign elig32   = rqst32 & ~served32_q;
   assign any_elig = elig8 | elig32;

   always_comb begin
      win        = SEL_8B;
      served8_d  = rqst8 & (served8_q | done8);
      served32_d = rqst32 & (served32_q | done32);
      unique case (1'b1)
         (elig8 & elig32):
            win = PRIO_32B ? SEL_32B : SEL_8B;
         (elig32 & ~elig8):
            win = SEL_32B;
         (elig8 & ~elig32):
            win = SEL_8B;
         default:
            win = SEL_8B;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         served8_q  <= 1'b0;
         served32_q <= 1'b0;
      end else begin
         served8_q  <= served8_d;
         served32_q <= served32_d;
      end
   end

endmodule

// File: rtl/page_walk_responder.sv
// Shared page walk engine for the 8B and 32B TLB lookup ports.
// Define PT_RESP_STATS_EN to add saturating per-port completion counters.
module page_walk_responder
   import page_walk_responder_pkg::*;
#(
   parameter int LAT_8B   = 4,
   parameter int LAT_32B  = 2,
   parameter bit PRIO_32B = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   page_walk_responder_if.slave pw
`ifdef PT_RESP_STATS_EN
   ,
   output logic [7:0] LOOKUP_CNT_8B,
   output logic [7:0] LOOKUP_CNT_32B
`endif
);

   localparam logic [3:0] LD8  = 4'(LAT_8B - 1);
   localparam logic [3:0] LD32 = 4'(LAT_32B - 1);

   state_t state_q, state_d;
   sel_t   sel_q, sel_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [VPN8_W-1:0]  addr_q, addr_d;
   logic [RET8_W-1:0]  recv8_q, recv8_d;
   logic [RET32_W-1:0] recv32_q, recv32_d;
   logic any_elig, done8, done32, walk_end;
   sel_t win;

   assign done8  = (state_q == ST_RESP) && (sel_q == SEL_8B);
   assign done32 = (state_q == ST_RESP) && (sel_q == SEL_32B);
   assign walk_end = (state_q == ST_WALK) && (cnt_q == 4'd0);

   assign pw.PAGE_8B_RECV      = recv8_q;
   assign pw.PAGE_32B_RECV     = recv32_q;
   assign pw.PAGE_8B_COMPLETE  = done8;
   assign pw.PAGE_32B_COMPLETE = done32;

   pwr_arbiter #(.PRIO_32B(PRIO_32B)) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .rqst8    (pw.PAGE_8B_RQST),
      .rqst32   (pw.PAGE_32B_RQST),
      .done8    (done8),
      .done32   (done32),
      .any_elig (any_elig),
      .win      (win)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      recv8_d  = recv8_q;
      recv32_d = recv32_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any_elig) begin
               sel_d   = win;
               state_d = ST_WALK;
               if (win == SEL_32B) begin
                  addr_d = {2'b00, pw.PAGE_32B_LOOKUP};
                  cnt_d  = LD32;
               end else begin
                  addr_d = pw.PAGE_8B_LOOKUP;
                  cnt_d  = LD8;
               end
            end
         end
         ST_WALK: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
               if (sel_q == SEL_8B)
                  recv8_d = xlate8(addr_q);
               else
                  recv32_d = xlate32(addr_q[3:0]);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         sel_q    <= SEL_8B;
         cnt_q    <= 4'd0;
         addr_q   <= '0;
         recv8_q  <= '0;
         recv32_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         recv8_q  <= recv8_d;
         recv32_q <= recv32_d;
      end
   end

`ifdef PT_RESP_STATS_EN
   logic [7:0] lc8_q, lc8_d, lc32_q, lc32_d;

   always_comb begin
      lc8_d  = lc8_q;
      lc32_d = lc32_q;
      if (walk_end && sel_q == SEL_8B && lc8_q != 8'hFF)
         lc8_d = lc8_q + 8'd1;
      if (walk_end && sel_q == SEL_32B && lc32_q != 8'hFF)
         lc32_d = lc32_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lc8_q  <= 8'd0;
         lc32_q <= 8'd0;
      end else begin
         lc8_q  <= lc8_d;
         lc32_q <= lc32_d;
      end
   end

   assign LOOKUP_CNT_8B  = lc8_q;
   assign LOOKUP_CNT_32B = lc32_q;
`else
   logic unused_walk_end;
   assign unused_walk_end = walk_end;
`endif

endmodule

// File: tb/tb_page_walk_responder.sv
// Directed bench for page_walk_responder (LAT_8B=4, LAT_32B=2, PRIO_32B=1).
// Stats checks run when PT_RESP_STATS_EN is defined.
module tb_page_walk_responder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;

   page_walk_responder_if bus();

`ifdef PT_RESP_STATS_EN
   logic [7:0] cnt8, cnt32;
`endif

   page_walk_responder #(
      .LAT_8B(4), .LAT_32B(2), .PRIO_32B(1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pw    (bus.slave)
`ifdef PT_RESP_STATS_EN
      ,
      .LOOKUP_CNT_8B  (cnt8),
      .LOOKUP_CNT_32B (cnt32)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.PAGE_8B_RQST    = 1'b0;
      bus.PAGE_8B_LOOKUP  = 6'h00;
      bus.PAGE_32B_RQST   = 1'b0;
      bus.PAGE_32B_LOOKUP = 4'h0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if (bus.PAGE_8B_RECV !== 12'h000) begin
         n_bad++;
         $display("FAIL rst_recv8 got %h want 000",
                  bus.PAGE_8B_RECV);
      end
      n_cmp++;
      if (bus.PAGE_32B_RECV !== 8'h00) begin
         n_bad++;
         $display("FAIL rst_recv32 got %h want 00",
                  bus.PAGE_32B_RECV);
      end
      n_cmp++;
      if ({bus.PAGE_8B_COMPLETE, bus.PAGE_32B_COMPLETE} !== 2'b00) begin
         n_bad++;
         $display("FAIL rst_complete got %b%b want 00",
                  bus.PAGE_8B_COMPLETE, bus.PAGE_32B_COMPLETE);
      end
`ifdef PT_RESP_STATS_EN
      n_cmp++;
      if ({cnt8, cnt32} !== 16'h0000) begin
         n_bad++;
         $display("FAIL rst_cnt got %h %h want 00 00", cnt8, cnt32);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_8b_single();
      bus.PAGE_8B_LOOKUP = 6'h15;
      bus.PAGE_8B_RQST   = 1'b1;
      for (int e = 0; e < 9; e++) begin
         tick();
         n_cmp++;
         if (bus.PAGE_8B_COMPLETE !== (e == 4)) begin
            n_bad++;
            $display("FAIL c8_single e%0d got %b want %b",
                     e, bus.PAGE_8B_COMPLETE, (e == 4));
         end
         n_cmp++;
         if (bus.PAGE_32B_COMPLETE !== 1'b0) begin
            n_bad++;
            $display("FAIL c32_quiet e%0d got %b want 0",
                     e, bus.PAGE_32B_COMPLETE);
         end
         if (e == 4) begin
            n_cmp++;
            if (bus.PAGE_8B_RECV !== 12'h575) begin
               n_bad++;
               $display("FAIL recv8_single got %h want 575",
                        bus.PAGE_8B_RECV);
            end
         end
      end
      bus.PAGE_8B_RQST = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_32b_single();
      logic [3:0] vpn [2];
      logic [7:0] exp [2];
      vpn[0] = 4'h6; exp[0] = 8'h6E;
      vpn[1] = 4'hA; exp[1] = 8'hAA;
      for (int k = 0; k < 2; k++) begin
         bus.PAGE_32B_LOOKUP = vpn[k];
         bus.PAGE_32B_RQST   = 1'b1;
         for (int e = 0; e < 6; e++) begin
            tick();
            n_cmp++;
            if (bus.PAGE_32B_COMPLETE !== (e == 2)) begin
               n_bad++;
               $display("FAIL c32_single k%0d e%0d got %b want %b",
                        k, e, bus.PAGE_32B_COMPLETE, (e == 2));
            end
            if (e == 2) begin
               n_cmp++;
               if (bus.PAGE_32B_RECV !== exp[k]) begin
                  n_bad++;
                  $display("FAIL recv32_single k%0d got %h want %h",
                           k, bus.PAGE_32B_RECV, exp[k]);
               end
            end
         end
         n_cmp++;
         if (bus.PAGE_8B_RECV !== 12'h575) begin
            n_bad++;
            $display("FAIL recv8_kept got %h want 575",
                     bus.PAGE_8B_RECV);
         end
         bus.PAGE_32B_RQST = 1'b0;
         tick();
         tick();
      end
   endtask

   task automatic test_simultaneous();
      bus.PAGE_8B_LOOKUP  = 6'h15;
      bus.PAGE_32B_LOOKUP = 4'h3;
      bus.PAGE_8B_RQST    = 1'b1;
      bus.PAGE_32B_RQST   = 1'b1;
      for (int e = 0; e < 12; e++) begin
         tick();
         n_cmp++;
         if (bus.PAGE_32B_COMPLETE !== (e == 2)) begin
            n_bad++;
            $display("FAIL c32_sim e%0d got %b want %b",
                     e, bus.PAGE_32B_COMPLETE, (e == 2));
         end
         n_cmp++;
         if (bus.PAGE_8B_COMPLETE !== (e == 8)) begin
            n_bad++;
            $display("FAIL c8_sim e%0d got %b want %b",
                     e, bus.PAGE_8B_COMPLETE, (e == 8));
         end
         if (e == 2) begin
            n_cmp++;
            if (bus.PAGE_32B_RECV !== 8'h3B) begin
               n_bad++;
               $display("FAIL recv32_sim got %h want 3B",
                        bus.PAGE_32B_RECV);
            end
         end
         if (e == 8) begin
            n_cmp++;
            if (bus.PAGE_8B_RECV !== 12'h575) begin
               n_bad++;
               $display("FAIL recv8_sim got %h want 575",
                        bus.PAGE_8B_RECV);
            end
         end
      end
      bus.PAGE_8B_RQST  = 1'b0;
      bus.PAGE_32B_RQST = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_held();
      int n8;
      n8 = 0;
      bus.PAGE_8B_LOOKUP = 6'h2A;
      bus.PAGE_8B_RQST   = 1'b1;
      for (int e = 0; e < 25; e++) begin
         tick();
         if (bus.PAGE_8B_COMPLETE === 1'b1) n8++;
      end
      n_cmp++;
      if (n8 !== 1) begin
         n_bad++;
         $display("FAIL held_once got %0d want 1", n8);
      end
      n_cmp++;
      if (bus.PAGE_8B_RECV !== 12'hAAA) begin
         n_bad++;
         $display("FAIL recv8_held got %h want AAA",
                  bus.PAGE_8B_RECV);
      end
      bus.PAGE_8B_RQST = 1'b0;
      tick();
      bus.PAGE_8B_RQST = 1'b1;
      bus.PAGE_8B_LOOKUP = 6'h07;
      for (int e = 0; e < 7; e++) begin
         tick();
         if (e == 1) bus.PAGE_8B_LOOKUP = 6'h00;
         n_cmp++;
         if (bus.PAGE_8B_COMPLETE !== (e == 4)) begin
            n_bad++;
            $display("FAIL c8_rerq e%0d got %b want %b",
                     e, bus.PAGE_8B_COMPLETE, (e == 4));
         end
         if (e == 4) begin
            n_cmp++;
            if (bus.PAGE_8B_RECV !== 12'h1E7) begin
               n_bad++;
               $display("FAIL recv8_latched got %h want 1E7",
                        bus.PAGE_8B_RECV);
            end
         end
      end
      bus.PAGE_8B_RQST = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset_midwalk();
      int n8;
      n8 = 0;
      bus.PAGE_8B_LOOKUP = 6'h15;
      bus.PAGE_8B_RQST   = 1'b1;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      bus.PAGE_8B_RQST = 1'b0;
      #1;
      n_cmp++;
      if (bus.PAGE_8B_RECV !== 12'h000) begin
         n_bad++;
         $display("FAIL mid_rst_recv8 got %h want 000",
                  bus.PAGE_8B_RECV);
      end
      n_cmp++;
      if (bus.PAGE_32B_RECV !== 8'h00) begin
         n_bad++;
         $display("FAIL mid_rst_recv32 got %h want 00",
                  bus.PAGE_32B_RECV);
      end
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         if (bus.PAGE_8B_COMPLETE === 1'b1) n8++;
      end
      n_cmp++;
      if (n8 !== 0) begin
         n_bad++;
         $display("FAIL mid_rst_none got %0d want 0", n8);
      end
      bus.PAGE_8B_LOOKUP = 6'h07;
      bus.PAGE_8B_RQST   = 1'b1;
      for (int e = 0; e < 6; e++) begin
         tick();
         n_cmp++;
         if (bus.PAGE_8B_COMPLETE !== (e == 4)) begin
            n_bad++;
            $display("FAIL c8_after_rst e%0d got %b want %b",
                     e, bus.PAGE_8B_COMPLETE, (e == 4));
         end
         if (e == 4) begin
            n_cmp++;
            if (bus.PAGE_8B_RECV !== 12'h1E7) begin
               n_bad++;
               $display("FAIL recv8_after_rst got %h want 1E7",
                        bus.PAGE_8B_RECV);
            end
         end
      end
      bus.PAGE_8B_RQST = 1'b0;
      tick();
      tick();
   endtask

`ifdef PT_RESP_STATS_EN
   task automatic test_stats();
      int wait_c;
      bit seen;
      bus.PAGE_32B_LOOKUP = 4'h5;
      for (int k = 1; k <= 300; k++) begin
         bus.PAGE_32B_RQST = 1'b1;
         seen = 1'b0;
         wait_c = 0;
         while (!seen && wait_c < 10) begin
            tick();
            wait_c++;
            if (bus.PAGE_32B_COMPLETE === 1'b1) seen = 1'b1;
         end
         bus.PAGE_32B_RQST = 1'b0;
         if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stats_timeout k%0d got none want complete", k);
         end
         if (k == 1 || k == 254 || k == 255 || k == 300) begin
            n_cmp++;
            if (cnt32 !== ((k > 255) ? 8'hFF : 8'(k))) begin
               n_bad++;
               $display("FAIL cnt32 k%0d got %h want %h", k, cnt32,
                        (k > 255) ? 8'hFF : 8'(k));
            end
         end
         tick();
      end
      n_cmp++;
      if (cnt8 !== 8'h00) begin
         n_bad++;
         $display("FAIL cnt8_quiet got %h want 00", cnt8);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_8b_single();
      test_32b_single();
      test_simultaneous();
      test_held();
      test_reset_midwalk();
`ifdef PT_RESP_STATS_EN
      rst_n = 1'b0;
      #1;
      test_reset();
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/page_walk_responder.md
Name: page_walk_responder

Overview:
- Responder end of the TLB page-table lookup interface: services the 8-byte-page port (PAGE_8B_*) and the 32-byte-page port (PAGE_32B_*) that the speculative TLB drives on a miss.
- A single shared walk engine serves both ports. It uses configurable per-port latency and fixed-priority arbitration.
- Translation rule is identity with the physical MSB forced to 1, so VA 0xxxxxxxx maps to PA 1xxxxxxxx.
- Replaces the two separate page-table models, so TLB benches can exercise contention between the two page sizes.

Parameters:
- LAT_8B, 4, cycles from request acceptance to PAGE_8B_COMPLETE; legal range 1..15.
- LAT_32B, 2, cycles from request acceptance to PAGE_32B_COMPLETE; legal range 1..15.
- PRIO_32B, 1, 1 = 32B port wins simultaneous requests; 0 = 8B port wins.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- PAGE_8B_RQST  input  1  level request from TLB, 8B page.
- PAGE_8B_LOOKUP  input  6  8B virtual page number, VA[8:3].
- PAGE_8B_RECV  output  12  {VPN[5:0], PPN[5:0]}.
- PAGE_8B_COMPLETE  output  1  one-cycle completion pulse.
- PAGE_32B_RQST  input  1  level request, 32B page.
- PAGE_32B_LOOKUP  input  4  32B virtual page number, VA[8:5].
- PAGE_32B_RECV  output  8  {VPN[3:0], PPN[3:0]}.
- PAGE_32B_COMPLETE  output  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - Asynchronous, on rst_n low.
  - All outputs go to 0, the FSM goes to IDLE, the latency counter clears, and both served flags clear.
  - Reset mid-walk abandons the walk; no COMPLETE is issued after release.
- Translation:
  - 8B: PPN = {1'b1, VPN[4:0]}.
  - 32B: PPN = {1'b1, VPN[3:1]... }, specifically PPN = {1'b1, VPN[2:0]}.
  - VPN MSB is echoed unchanged in the RECV tag field.
- Eligibility: a port is eligible when its RQST = 1 and its served flag = 0.
- FSM:
  - IDLE: on an edge with at least one eligible port, select a winner. The PRIO_32B winner takes priority if both are eligible. On that edge:
    - latch the winner's LOOKUP address;
    - load the counter with LAT_x - 1;
    - go to WALK.
    - The losing port keeps its request pending; it is not latched.
  - WALK: decrement the counter each edge. When the counter = 0, register RECV for the active port and go to RESP.
  - RESP: the active port's COMPLETE = 1 for exactly this one cycle. Set that port's served flag. Return to IDLE on the next edge.
- Served flag: cleared on any edge where the port's RQST = 0. This prevents re-servicing a request that the TLB has not yet dropped.
- Latency: acceptance edge E; COMPLETE is high between edge E+LAT and edge E+LAT+1.
- Back-to-back: the minimum gap between completions on the shared engine is LAT+2 cycles, counting the IDLE arbitration cycle.
- RECV retention: RECV is held stable after COMPLETE until the next completion on the same port. The other port's RECV is never disturbed.
- LOOKUP changes: changes while in WALK are ignored because the address is latched at acceptance.
- RQST dropped mid-walk: the walk still completes and pulses COMPLETE. The requester ignores it.
- Concurrency: never more than one COMPLETE high at a time.

Optional Feature:
- Macro: PT_RESP_STATS_EN.
- Defined: adds output ports LOOKUP_CNT_8B[7:0] and LOOKUP_CNT_32B[7:0].
  - Each counts the completions on its port.
  - Counts saturate at 8'hFF and reset to 0.
  - Each increments on the same edge that enters RESP for that port.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, WALK, RESP);
  - port-select enum (SEL_8B, SEL_32B);
  - widths VPN8_W=6, VPN32_W=4, RET8_W=12, RET32_W=8;
  - PA_MSB_SET=1'b1.
- One natural sub-module: pwr_arbiter. It is combinational eligibility plus priority select, and owns the served-flag registers.
- Translation functions are package functions.

Test Plan:
- 8B single lookup: reset, then PAGE_8B_RQST=1, LOOKUP=6'h15 at edge 0. Expect PAGE_8B_COMPLETE high between edges 4 and 5, PAGE_8B_RECV=12'h575, and no 32B activity.
- 32B single lookup: LOOKUP=4'h6 with LAT_32B=2. Expect COMPLETE high between edges 2 and 3 with RECV=8'h6E. A second lookup of 4'hA returns 8'hAA.
- Simultaneous requests (PRIO_32B=1), both held: 32B completes at edge 2. 8B is accepted at edge 4 and completes at edge 8, returning 12'h575 for VPN 6'h15. The two COMPLETE signals never overlap.
- Held request: RQST kept high for 20 cycles after COMPLETE. Expect exactly one COMPLETE. Drop RQST for one cycle, re-raise it, and a second COMPLETE follows after LAT.
- Reset mid-walk: rst_n=0 two edges after 8B acceptance. Expect outputs 0 immediately and no COMPLETE after release. A new request completes normally.
- PT_RESP_STATS_EN: issue 300 32B lookups. LOOKUP_CNT_32B saturates at 8'hFF and LOOKUP_CNT_8B stays 0.
